// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between instruction fetch and load/store data access.
// Data has fixed priority over fetch, and only one transaction is in flight at a time.
// Each requester holds its request until it sees a one-cycle valid pulse.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a watchdog.
// A transaction that is still in ISSUE/WAIT after TIMEOUT_CYCLES cycles completes with err=1.
// The selected rdata is forced to 0 in that case.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                grant_src,
  output logic                err
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic              m_req_reg, m_req_next;
  logic              m_we_reg, m_we_next;
  logic [ADDR_W-1:0] m_addr_reg, m_addr_next;
  logic [DATA_W-1:0] m_wdata_reg, m_wdata_next;
  logic [STRB_W-1:0] m_wstrb_reg, m_wstrb_next;
  logic              grant_src_reg, grant_src_next;
  logic              if_valid_reg, if_valid_next;
  logic              d_valid_reg, d_valid_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;
  logic              err_reg, err_next;

  // High in the last ISSUE/WAIT cycle a transaction is allowed to occupy
  logic timeout_hit;

  // A zero limit would make the watchdog fire before the memory could ever answer
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_reg;

  // Watchdog: cleared while idle, counts every cycle spent in ISSUE or WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == ISSUE || state_reg == WAIT) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end else begin
      tmo_cnt_reg <= '0;
    end
  end

  // The count reaches TIMEOUT_CYCLES at this edge, so RESP follows directly
  assign timeout_hit = (state_reg == ISSUE || state_reg == WAIT) && (tmo_cnt_reg == TMO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a real response in WAIT wins over a coincident timeout
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (d_req || if_req) state_next = ISSUE;
      end
      ISSUE: begin
        if (timeout_hit)  state_next = RESP;
        else if (m_gnt)   state_next = WAIT;
      end
      WAIT: begin
        if (m_rvalid || timeout_hit) state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    m_req_next     = m_req_reg;
    m_we_next      = m_we_reg;
    m_addr_next    = m_addr_reg;
    m_wdata_next   = m_wdata_reg;
    m_wstrb_next   = m_wstrb_reg;
    grant_src_next = grant_src_reg;
    if_rdata_next  = if_rdata_reg;
    d_rdata_next   = d_rdata_reg;
    if_valid_next  = 1'b0;
    d_valid_next   = 1'b0;
    err_next       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (d_req) begin
          m_req_next     = 1'b1;
          m_we_next      = d_we;
          m_addr_next    = d_addr;
          m_wdata_next   = d_wdata;
          m_wstrb_next   = d_wstrb;
          grant_src_next = 1'b1;
        end else if (if_req) begin
          m_req_next     = 1'b1;
          m_we_next      = 1'b0;
          m_addr_next    = if_addr;
          m_wdata_next   = '0;
          m_wstrb_next   = '0;
          grant_src_next = 1'b0;
        end
      end
      ISSUE: begin
        if (timeout_hit) begin
          m_req_next = 1'b0;
          err_next   = 1'b1;
          if (grant_src_reg) begin
            d_valid_next = 1'b1;
            d_rdata_next = '0;
          end else begin
            if_valid_next = 1'b1;
            if_rdata_next = '0;
          end
        end else if (m_gnt) begin
          m_req_next = 1'b0;
        end
      end
      WAIT: begin
        if (m_rvalid) begin
          if (grant_src_reg) begin
            d_valid_next = 1'b1;
            d_rdata_next = m_rdata;
          end else begin
            if_valid_next = 1'b1;
            if_rdata_next = m_rdata;
          end
        end else if (timeout_hit) begin
          err_next = 1'b1;
          if (grant_src_reg) begin
            d_valid_next = 1'b1;
            d_rdata_next = '0;
          end else begin
            if_valid_next = 1'b1;
            if_rdata_next = '0;
          end
        end
      end
      default: ;
    endcase
  end

  // Output registers; reset aborts any transaction without a response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req_reg     <= 1'b0;
      m_we_reg      <= 1'b0;
      m_addr_reg    <= '0;
      m_wdata_reg   <= '0;
      m_wstrb_reg   <= '0;
      grant_src_reg <= 1'b0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
      if_valid_reg  <= 1'b0;
      d_valid_reg   <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      m_req_reg     <= m_req_next;
      m_we_reg      <= m_we_next;
      m_addr_reg    <= m_addr_next;
      m_wdata_reg   <= m_wdata_next;
      m_wstrb_reg   <= m_wstrb_next;
      grant_src_reg <= grant_src_next;
      if_rdata_reg  <= if_rdata_next;
      d_rdata_reg   <= d_rdata_next;
      if_valid_reg  <= if_valid_next;
      d_valid_reg   <= d_valid_next;
      err_reg       <= err_next;
    end
  end

  assign m_req     = m_req_reg;
  assign m_we      = m_we_reg;
  assign m_addr    = m_addr_reg;
  assign m_wdata   = m_wdata_reg;
  assign m_wstrb   = m_wstrb_reg;
  assign grant_src = grant_src_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign if_valid  = if_valid_reg;
  assign d_valid   = d_valid_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// The timeout scenario runs only when MEM_ARB_TIMEOUT_EN is defined (TIMEOUT_CYCLES=8).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        grant_src;
  logic        err;

  int tests_run = 0;
  int tests_failed = 0;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .grant_src(grant_src), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant in the first ISSUE cycle, respond in the following cycle
  task automatic mem_cycle(input logic [31:0] rdata);
    m_gnt = 1'b1;
    tick();
    m_gnt    = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = rdata;
    tick();
    m_rvalid = 1'b0;
    m_rdata  = 32'h0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".m_req"}, m_req, 1'b0);
    check({tag, ".m_we"}, m_we, 1'b0);
    check({tag, ".m_addr"}, m_addr, 32'h0);
    check({tag, ".m_wdata"}, m_wdata, 32'h0);
    check({tag, ".m_wstrb"}, m_wstrb, 4'h0);
    check({tag, ".grant_src"}, grant_src, 1'b0);
    check({tag, ".if_valid"}, if_valid, 1'b0);
    check({tag, ".d_valid"}, d_valid, 1'b0);
    check({tag, ".if_rdata"}, if_rdata, 32'h0);
    check({tag, ".d_rdata"}, d_rdata, 32'h0);
    check({tag, ".err"}, err, 1'b0);
  endtask

  // Hard stop in case the run ever wanders off
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Fetch only
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    check("fetch.m_req", m_req, 1'b1);
    check("fetch.m_addr", m_addr, 32'h100);
    check("fetch.m_we", m_we, 1'b0);
    check("fetch.m_wstrb", m_wstrb, 4'h0);
    check("fetch.grant_src", grant_src, 1'b0);
    m_gnt = 1'b1;
    tick();
    check("fetch.m_req_drop", m_req, 1'b0);
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h00500093;
    tick();
    m_rvalid = 1'b0;
    check("fetch.if_valid", if_valid, 1'b1);
    check("fetch.if_rdata", if_rdata, 32'h00500093);
    check("fetch.d_valid", d_valid, 1'b0);
    check("fetch.err", err, 1'b0);
    if_req = 1'b0;
    tick();
    check("fetch.if_valid_pulse", if_valid, 1'b0);
    $display("[TB] fetch 0x100 -> 0x%08h", if_rdata);

    // Simultaneous store and fetch: store first
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    if_req = 1'b1; if_addr = 32'h104;
    tick();
    check("sim.m_req", m_req, 1'b1);
    check("sim.m_we", m_we, 1'b1);
    check("sim.grant_src", grant_src, 1'b1);
    check("sim.m_addr", m_addr, 32'h2000);
    check("sim.m_wdata", m_wdata, 32'hDEADBEEF);
    check("sim.m_wstrb", m_wstrb, 4'hF);
    mem_cycle(32'h0);
    check("sim.d_valid", d_valid, 1'b1);
    check("sim.if_valid_low", if_valid, 1'b0);
    check("sim.if_rdata_hold", if_rdata, 32'h00500093);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    check("sim.d_valid_pulse", d_valid, 1'b0);
    check("sim.idle_m_req", m_req, 1'b0);
    $display("[TB] store 0x2000 <- 0xDEADBEEF done");
    tick();
    check("sim.f_m_req", m_req, 1'b1);
    check("sim.f_m_addr", m_addr, 32'h104);
    check("sim.f_grant_src", grant_src, 1'b0);
    check("sim.f_m_we", m_we, 1'b0);
    check("sim.f_m_wstrb", m_wstrb, 4'h0);
    mem_cycle(32'h12345678);
    check("sim.f_if_valid", if_valid, 1'b1);
    check("sim.f_if_rdata", if_rdata, 32'h12345678);
    check("sim.f_d_valid", d_valid, 1'b0);
    if_req = 1'b0;
    tick();
    $display("[TB] fetch 0x104 -> 0x%08h", if_rdata);

    // Grant backpressure with a stray rvalid during ISSUE
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_wdata = 32'h55; d_wstrb = 4'h0;
    tick();
    d_addr = 32'h9999; d_wdata = 32'hAAAA;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp.m_req[%0d]", i), m_req, 1'b1);
      check($sformatf("bp.m_addr[%0d]", i), m_addr, 32'h3000);
      check($sformatf("bp.m_wdata[%0d]", i), m_wdata, 32'h55);
      check($sformatf("bp.d_valid[%0d]", i), d_valid, 1'b0);
      m_rvalid = (i == 2); m_rdata = 32'hBAD0BAD0;
      tick();
    end
    m_rvalid = 1'b0;
    mem_cycle(32'hCAFEF00D);
    check("bp.d_valid", d_valid, 1'b1);
    check("bp.d_rdata", d_rdata, 32'hCAFEF00D);
    d_req = 1'b0;
    tick();
    check("bp.d_valid_pulse", d_valid, 1'b0);
    $display("[TB] load 0x3000 with backpressure -> 0x%08h", d_rdata);

    // Request held through its own valid cycle
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    tick();
    check("hold.m_req", m_req, 1'b1);
    mem_cycle(32'h11112222);
    check("hold.d_valid", d_valid, 1'b1);
    check("hold.d_rdata", d_rdata, 32'h11112222);
    tick();
    d_req = 1'b0;
    check("hold.d_valid_pulse", d_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hold.no_reissue[%0d]", i), m_req, 1'b0);
      tick();
    end
    $display("[TB] held load 0x40 -> 0x%08h", d_rdata);

    // Reset during WAIT, leftover rvalid after release
    if_req = 1'b1; if_addr = 32'h200;
    tick();
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0; if_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_wait");
    tick();
    rst_n = 1'b1;
    m_rvalid = 1'b1; m_rdata = 32'h77777777;
    tick();
    m_rvalid = 1'b0;
    check("rst.if_valid", if_valid, 1'b0);
    check("rst.d_valid", d_valid, 1'b0);
    check("rst.m_req", m_req, 1'b0);
    tick();
    check("rst.if_valid2", if_valid, 1'b0);
    check("rst.if_rdata", if_rdata, 32'h0);
    if_req = 1'b1; if_addr = 32'h300;
    tick();
    check("rst.next_m_req", m_req, 1'b1);
    check("rst.next_m_addr", m_addr, 32'h300);
    mem_cycle(32'h0A0B0C0D);
    check("rst.next_if_valid", if_valid, 1'b1);
    check("rst.next_if_rdata", if_rdata, 32'h0A0B0C0D);
    if_req = 1'b0;
    tick();
    $display("[TB] reset mid-WAIT, then fetch 0x300 -> 0x%08h", if_rdata);

`ifdef MEM_ARB_TIMEOUT_EN
    // Load that never gets a response: valid with err 8 cycles after ISSUE entry
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    tick();
    check("tmo.m_req", m_req, 1'b1);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    for (int c = 2; c < 9; c++) begin
      check($sformatf("tmo.d_valid_c%0d", c), d_valid, 1'b0);
      check($sformatf("tmo.err_c%0d", c), err, 1'b0);
      tick();
    end
    check("tmo.d_valid", d_valid, 1'b1);
    check("tmo.err", err, 1'b1);
    check("tmo.d_rdata", d_rdata, 32'h0);
    check("tmo.m_req", m_req, 1'b0);
    d_req = 1'b0;
    tick();
    check("tmo.err_clear", err, 1'b0);
    check("tmo.d_valid_pulse", d_valid, 1'b0);
    tick();
    check("tmo.idle_m_req", m_req, 1'b0);
    $display("[TB] load 0x500 timed out, err reported");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external memory port between instruction fetch and load/store data access, for unified-memory builds of the RV32I core.
- Fixed priority: data over fetch. One transaction outstanding at a time.
- Each requester holds its request until it sees a one-cycle valid pulse, and stalls until then.
- Sits between the core's fetch/LSU interfaces and the memory/bus model.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; strobe width is DATA_W/8
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with MEM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch data; qualified by if_valid
- if_valid  out  1  fetch response pulse
- d_req  in  1  data request; held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  store byte strobes
- d_rdata  out  DATA_W  load data; qualified by d_valid
- d_valid  out  1  data response pulse
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_wstrb  out  DATA_W/8  memory strobes
- m_gnt  in  1  memory accepts request (when m_req=1)
- m_rvalid  in  1  memory response/ack; also sent for stores
- m_rdata  in  DATA_W  memory read data
- grant_src  out  1  source of latched transaction: 0 = fetch, 1 = data
- err  out  1  timeout error; qualified by if_valid/d_valid

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- Reset (async, rst_n=0): state IDLE. All outputs are 0: if_valid, d_valid, m_req, m_we, m_addr, m_wdata, m_wstrb, grant_src, err, if_rdata, d_rdata.
- IDLE:
  - If d_req=1: latch d_we, d_addr, d_wdata, d_wstrb into the m_* registers; set grant_src=1; go to ISSUE.
  - Else if if_req=1: latch if_addr with m_we=0 and m_wstrb=0; set grant_src=0; go to ISSUE.
  - Both requests present in the same cycle: data wins. Fetch stays pending and is served after RESP.
- ISSUE: m_req=1. On m_gnt=1, go to WAIT and drop m_req in the next cycle. m_rvalid is ignored in this state.
- WAIT: m_req=0. On m_rvalid=1, capture m_rdata into d_rdata (grant_src=1) or if_rdata (grant_src=0), then go to RESP.
- RESP: the selected valid (d_valid or if_valid) is high for exactly one cycle, then the FSM returns to IDLE.
  - No new request is accepted in RESP, so a request still held during its own valid cycle is not re-issued.
- Minimum latency is 3 cycles from request to valid: req@0, m_req/m_gnt@1, m_rvalid@2, valid@3.
- The memory must not assert m_rvalid in the same cycle as m_gnt.
- m_* outputs stay stable from IDLE exit until RESP. Requester inputs that change after acceptance have no effect.
- The non-selected rdata output holds its previous value.
- Stores: d_rdata is written with m_rdata, and its content is don't-care.
- m_rvalid arriving in IDLE, ISSUE or RESP (stray, or a leftover after reset) is ignored.
- Reset mid-transaction: immediate return to IDLE with outputs cleared. No valid is produced for the aborted request.
- Addresses pass through unmodified. Alignment is the requester's responsibility.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter, width clog2(TIMEOUT_CYCLES+1), clears on IDLE exit and counts every cycle in ISSUE and WAIT.
  - When the count reaches TIMEOUT_CYCLES, the FSM goes to RESP with err=1 and the selected rdata set to 0. m_req drops.
  - err clears in the cycle after RESP.
  - A late m_rvalid for the abandoned transaction is ignored unless the FSM is in WAIT for a new transaction. Documented limitation: the bench must not produce that case.
- Undefined: no counter; err is tied to 0; the FSM waits indefinitely.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100; m_gnt in first ISSUE cycle; m_rvalid next cycle with m_rdata=0x00500093 -> m_addr=0x100, m_we=0, if_valid pulse at cycle 3 with if_rdata=0x00500093, d_valid stays 0.
- Simultaneous requests: d_req (store, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=0xF) and if_req in the same cycle -> store issued first (m_we=1, grant_src=1); d_valid pulse, then fetch issued; if_valid follows.
- Grant backpressure: m_gnt held 0 for 5 cycles -> m_req stays 1 with stable m_addr/m_wdata; single valid pulse after gnt and rvalid.
- Held request: requester keeps d_req=1 through its d_valid cycle, then drops it -> exactly one memory transaction, no duplicate m_req.
- Reset mid-WAIT: rst_n low during WAIT; m_rvalid arrives after release -> all outputs 0, no valid pulse, rvalid ignored, next request served normally.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8: load, no m_rvalid -> d_valid with err=1 and d_rdata=0 eight cycles after ISSUE entry, FSM back in IDLE.
